// File: rtl/iir_out_capture_if.sv
// Bus between the filter-output capture sink and its environment.
// Optional CHKSUM signal exists only when IIR_CAPTURE_CHECKSUM_EN is defined.
//
// Handshake rules: VOUT qualifies DOUT on the cycle it is high (no back-pressure,
// the filter never waits); VIN is only observed to time the first input sample;
// a pop is accepted on any cycle with RD_REQ=1 and EMPTY=0, and RD_VALID is high
// for exactly the one cycle after, qualifying RD_DATA.
interface iir_out_capture_if #(
   parameter int NB = 12,
   parameter int CW = 16
);
   logic          START;
   logic [CW-1:0] NSAMP;
   logic          VIN;
   logic          VOUT;
   logic [NB-1:0] DOUT;
   logic          RD_REQ;
   logic [NB-1:0] RD_DATA;
   logic          RD_VALID;
   logic          EMPTY;
   logic          FULL;
   logic          BUSY;
   logic          DONE;
   logic [CW-1:0] LAT;
   logic [CW-1:0] DROPS;
   logic          OVF;
`ifdef IIR_CAPTURE_CHECKSUM_EN
   logic [NB-1:0] CHKSUM;

   modport master (
      output START, NSAMP, VIN, VOUT, DOUT, RD_REQ,
      input  RD_DATA, RD_VALID, EMPTY, FULL, BUSY, DONE, LAT, DROPS, OVF, CHKSUM
   );
   modport slave (
      input  START, NSAMP, VIN, VOUT, DOUT, RD_REQ,
      output RD_DATA, RD_VALID, EMPTY, FULL, BUSY, DONE, LAT, DROPS, OVF, CHKSUM
   );
`else
   modport master (
      output START, NSAMP, VIN, VOUT, DOUT, RD_REQ,
      input  RD_DATA, RD_VALID, EMPTY, FULL, BUSY, DONE, LAT, DROPS, OVF
   );
   modport slave (
      input  START, NSAMP, VIN, VOUT, DOUT, RD_REQ,
      output RD_DATA, RD_VALID, EMPTY, FULL, BUSY, DONE, LAT, DROPS, OVF
   );
`endif
endinterface

// File: rtl/iir_out_capture.sv
// Filter output capture sink: measures VIN->VOUT latency, stores NSAMP output
// samples in a FIFO and hands them back through a registered pop port.
// Optional feature macro: IIR_CAPTURE_CHECKSUM_EN (adds a rotate-xor CHKSUM).
module iir_out_capture #(
   parameter int NB    = 12,
   parameter int DEPTH = 16,
   parameter int AW    = 4,
   parameter int CW    = 16
) (
   input  logic              CLK,
   input  logic              RST,
   iir_out_capture_if.slave  bus,
   output logic [1:0]        o_dbg_state
);

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_MEASURE, S_CAPTURE} state_t;

   localparam logic [CW-1:0] ONE_CW   = CW'(1);
   localparam logic [CW-1:0] SAT_CW   = {CW{1'b1}};
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

   state_t          r_state;
   state_t          w_state_nxt;
   logic [CW-1:0]   r_lat;
   logic [CW-1:0]   r_drops;
   logic            r_ovf;
   logic            r_done;
   logic [CW-1:0]   r_smp_cnt;
   logic [CW-1:0]   r_nsamp;
   logic [CW-1:0]   w_smp_cnt_inc;
   logic            w_last;

   // FSM control strobes
   logic            w_cnt_smp;
   logic            w_lat_clr;
   logic            w_lat_one;
   logic            w_lat_inc;

   // FIFO
   logic [NB-1:0]   r_mem [DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [AW:0]     r_count;
   logic [NB-1:0]   r_rd_data;
   logic            r_rd_valid;
   logic            w_full;
   logic            w_empty;
   logic            w_pop;
   logic            w_wr;
   logic            w_drop;

   assign w_smp_cnt_inc = r_smp_cnt + ONE_CW;
   assign w_last        = (w_smp_cnt_inc == r_nsamp);

   assign w_full  = (r_count == FULL_CNT);
   assign w_empty = (r_count == '0);
   assign w_pop   = bus.RD_REQ && !w_empty;
   // A full FIFO still accepts a write when a pop frees the slot on the same edge.
   assign w_wr    = w_cnt_smp && (!w_full || w_pop);
   assign w_drop  = w_cnt_smp && w_full && !w_pop;

   // State register
   always_ff @(posedge CLK) begin
      if (RST) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state and control strobes; START restarts the run from any state
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_smp   = 1'b0;
      w_lat_clr   = 1'b0;
      w_lat_one   = 1'b0;
      w_lat_inc   = 1'b0;
      if (bus.START) begin
         w_state_nxt = S_ARMED;
      end else begin
         case (r_state)
            S_ARMED: begin
               if (bus.VIN) begin
                  if (bus.VOUT) begin
                     w_lat_clr   = 1'b1;
                     w_cnt_smp   = 1'b1;
                     w_state_nxt = S_CAPTURE;
                  end else begin
                     w_lat_one   = 1'b1;
                     w_state_nxt = S_MEASURE;
                  end
               end
            end
            S_MEASURE: begin
               if (bus.VOUT) begin
                  w_cnt_smp   = 1'b1;
                  w_state_nxt = S_CAPTURE;
               end else begin
                  w_lat_inc = 1'b1;
               end
            end
            S_CAPTURE: begin
               if (bus.VOUT) w_cnt_smp = 1'b1;
            end
            default: w_state_nxt = r_state;
         endcase
         if (w_cnt_smp && w_last) w_state_nxt = S_IDLE;
      end
   end

   // Run bookkeeping: latency, sample count, drops, sticky flags
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_lat     <= '0;
         r_drops   <= '0;
         r_ovf     <= 1'b0;
         r_done    <= 1'b0;
         r_smp_cnt <= '0;
         r_nsamp   <= ONE_CW;
      end else if (bus.START) begin
         r_lat     <= '0;
         r_drops   <= '0;
         r_ovf     <= 1'b0;
         r_done    <= 1'b0;
         r_smp_cnt <= '0;
         r_nsamp   <= (bus.NSAMP == '0) ? ONE_CW : bus.NSAMP;
      end else begin
         if (w_lat_clr)                          r_lat <= '0;
         else if (w_lat_one)                     r_lat <= ONE_CW;
         else if (w_lat_inc && r_lat != SAT_CW)  r_lat <= r_lat + ONE_CW;
         if (w_cnt_smp) begin
            r_smp_cnt <= w_smp_cnt_inc;
            if (w_last) r_done <= 1'b1;
         end
         if (w_drop) begin
            r_ovf <= 1'b1;
            if (r_drops != SAT_CW) r_drops <= r_drops + ONE_CW;
         end
      end
   end

   // FIFO storage; contents need no reset because the pointers define validity
   always_ff @(posedge CLK) begin
      if (w_wr) r_mem[r_wr_ptr] <= bus.DOUT;
   end

   // FIFO pointers, occupancy and registered pop port
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         r_rd_valid <= w_pop;
         if (w_pop) begin
            r_rd_data <= r_mem[r_rd_ptr];
            r_rd_ptr  <= r_rd_ptr + 1'b1;
         end
         if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_wr && !w_pop)      r_count <= r_count + 1'b1;
         else if (!w_wr && w_pop) r_count <= r_count - 1'b1;
      end
   end

`ifdef IIR_CAPTURE_CHECKSUM_EN
   logic [NB-1:0] r_chk;

   // Rotate-xor signature over every counted sample, dropped ones included
   always_ff @(posedge CLK) begin
      if (RST || bus.START) r_chk <= '0;
      else if (w_cnt_smp)   r_chk <= {r_chk[NB-2:0], r_chk[NB-1]} ^ bus.DOUT;
   end

   assign bus.CHKSUM = r_chk;
`endif

   assign bus.RD_DATA  = r_rd_data;
   assign bus.RD_VALID = r_rd_valid;
   assign bus.EMPTY    = w_empty;
   assign bus.FULL     = w_full;
   assign bus.BUSY     = (r_state != S_IDLE);
   assign bus.DONE     = r_done;
   assign bus.LAT      = r_lat;
   assign bus.DROPS    = r_drops;
   assign bus.OVF      = r_ovf;
   assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_iir_out_capture.sv
// Directed testbench for iir_out_capture: latency, capture order, overflow,
// full read/write, empty pop, reset mid-run and (optionally) the checksum.
module tb_iir_out_capture;

   localparam int NB = 12;
   localparam int CW = 16;

   logic       CLK;
   logic       RST;
   logic [1:0] dbg_state;

   int errors = 0;
   int checks = 0;

   logic [NB-1:0] exp_q[$];

   iir_out_capture_if #(.NB(NB), .CW(CW)) bus ();

   iir_out_capture #(.NB(NB), .DEPTH(16), .AW(4), .CW(CW)) dut (
      .CLK         (CLK),
      .RST         (RST),
      .bus         (bus),
      .o_dbg_state (dbg_state)
   );

   // clock / reset
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_inputs();
      bus.START  = 1'b0;
      bus.NSAMP  = '0;
      bus.VIN    = 1'b0;
      bus.VOUT   = 1'b0;
      bus.DOUT   = '0;
      bus.RD_REQ = 1'b0;
   endtask

   task automatic pulse_start(input logic [CW-1:0] n);
      bus.START = 1'b1;
      bus.NSAMP = n;
      step();
      bus.START = 1'b0;
   endtask

   task automatic drive_sample(input logic [NB-1:0] d);
      bus.VOUT = 1'b1;
      bus.DOUT = d;
      step();
      bus.VOUT = 1'b0;
   endtask

   // pops every expected sample and compares it against the scoreboard
   task automatic drain(input string name);
      logic [NB-1:0] e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         bus.RD_REQ = 1'b1;
         step();
         bus.RD_REQ = 1'b0;
         checks++;
         if (bus.RD_VALID !== 1'b1 || bus.RD_DATA !== e) begin
            errors++;
            $display("FAIL %s pop: got valid=%b data=%h expected valid=1 data=%h",
                     name, bus.RD_VALID, bus.RD_DATA, e);
         end
      end
      checks++;
      if (bus.EMPTY !== 1'b1) begin
         errors++;
         $display("FAIL %s empty after drain: got %b expected 1", name, bus.EMPTY);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      clear_inputs();
      RST = 1'b1;
      step();
      step();
      RST = 1'b0;
      checks++;
      if ({bus.EMPTY, bus.FULL, bus.BUSY, bus.DONE, bus.OVF, bus.RD_VALID} !== 6'b100000) begin
         errors++;
         $display("FAIL reset flags: got E/F/B/D/O/V=%b expected 100000",
                  {bus.EMPTY, bus.FULL, bus.BUSY, bus.DONE, bus.OVF, bus.RD_VALID});
      end
      checks++;
      if (bus.LAT !== 16'd0 || bus.DROPS !== 16'd0 || bus.RD_DATA !== 12'h000) begin
         errors++;
         $display("FAIL reset counters: got lat=%0d drops=%0d rd_data=%h expected 0/0/000",
                  bus.LAT, bus.DROPS, bus.RD_DATA);
      end
      checks++;
      if (dbg_state !== 2'd0) begin
         errors++;
         $display("FAIL reset state: got %0d expected 0", dbg_state);
      end
   endtask

   task automatic test_latency_basic();
      logic [NB-1:0] vals [4];
      vals = '{12'h001, 12'h7FF, 12'h800, 12'hFFF};
      pulse_start(16'd4);
      checks++;
      if (bus.BUSY !== 1'b1 || bus.DONE !== 1'b0) begin
         errors++;
         $display("FAIL basic armed: got busy=%b done=%b expected 1/0", bus.BUSY, bus.DONE);
      end
      bus.VIN = 1'b1;      // t0
      step();
      bus.VIN = 1'b0;
      step();              // t0+1
      step();              // t0+2
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(vals[i]);
         drive_sample(vals[i]);   // first one at t0+3
      end
      checks++;
      if (bus.LAT !== 16'd3) begin
         errors++;
         $display("FAIL basic latency: got %0d expected 3", bus.LAT);
      end
      checks++;
      if (bus.DONE !== 1'b1 || bus.BUSY !== 1'b0) begin
         errors++;
         $display("FAIL basic done: got done=%b busy=%b expected 1/0", bus.DONE, bus.BUSY);
      end
      drain("basic");
   endtask

   task automatic test_overflow();
      pulse_start(16'd20);
      bus.VIN = 1'b1;
      step();
      bus.VIN = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         if (i <= 16) exp_q.push_back(NB'(i));
         drive_sample(NB'(i));
         if (i == 15) begin
            checks++;
            if (bus.FULL !== 1'b0) begin
               errors++;
               $display("FAIL ovf full at 15: got %b expected 0", bus.FULL);
            end
         end
         if (i == 16) begin
            checks++;
            if (bus.FULL !== 1'b1 || bus.DROPS !== 16'd0) begin
               errors++;
               $display("FAIL ovf full at 16: got full=%b drops=%0d expected 1/0",
                        bus.FULL, bus.DROPS);
            end
         end
      end
      checks++;
      if (bus.DROPS !== 16'd4 || bus.OVF !== 1'b1) begin
         errors++;
         $display("FAIL ovf drops: got drops=%0d ovf=%b expected 4/1", bus.DROPS, bus.OVF);
      end
      checks++;
      if (bus.DONE !== 1'b1 || bus.LAT !== 16'd1) begin
         errors++;
         $display("FAIL ovf done/lat: got done=%b lat=%0d expected 1/1", bus.DONE, bus.LAT);
      end
      drain("ovf");
   endtask

   task automatic test_full_rw();
      pulse_start(16'd17);
      // VIN and VOUT together: zero latency, sample captured immediately
      bus.VIN  = 1'b1;
      bus.VOUT = 1'b1;
      bus.DOUT = 12'h100;
      exp_q.push_back(12'h100);
      step();
      bus.VIN  = 1'b0;
      bus.VOUT = 1'b0;
      checks++;
      if (bus.LAT !== 16'd0 || dbg_state !== 2'd3) begin
         errors++;
         $display("FAIL fullrw zero latency: got lat=%0d state=%0d expected 0/3",
                  bus.LAT, dbg_state);
      end
      for (int i = 1; i < 16; i++) begin
         exp_q.push_back(NB'(12'h100 + i));
         drive_sample(NB'(12'h100 + i));
      end
      checks++;
      if (bus.FULL !== 1'b1) begin
         errors++;
         $display("FAIL fullrw full: got %b expected 1", bus.FULL);
      end
      // write and pop together while full
      bus.VOUT   = 1'b1;
      bus.DOUT   = 12'h0AA;
      bus.RD_REQ = 1'b1;
      step();
      bus.VOUT   = 1'b0;
      bus.RD_REQ = 1'b0;
      void'(exp_q.pop_front());
      exp_q.push_back(12'h0AA);
      checks++;
      if (bus.RD_VALID !== 1'b1 || bus.RD_DATA !== 12'h100) begin
         errors++;
         $display("FAIL fullrw oldest: got valid=%b data=%h expected 1/100",
                  bus.RD_VALID, bus.RD_DATA);
      end
      checks++;
      if (bus.FULL !== 1'b1 || bus.DROPS !== 16'd0 || bus.OVF !== 1'b0 || bus.DONE !== 1'b1) begin
         errors++;
         $display("FAIL fullrw flags: got full=%b drops=%0d ovf=%b done=%b expected 1/0/0/1",
                  bus.FULL, bus.DROPS, bus.OVF, bus.DONE);
      end
      drain("fullrw");
   endtask

   task automatic test_empty_pop();
      bus.RD_REQ = 1'b1;
      step();
      bus.RD_REQ = 1'b0;
      checks++;
      if (bus.RD_VALID !== 1'b0 || bus.RD_DATA !== 12'h0AA) begin
         errors++;
         $display("FAIL empty pop: got valid=%b data=%h expected 0/0aa",
                  bus.RD_VALID, bus.RD_DATA);
      end
      pulse_start(16'd2);
      drive_sample(12'h005);   // no VIN yet: ignored
      drive_sample(12'h006);
      checks++;
      if (bus.EMPTY !== 1'b1 || bus.BUSY !== 1'b1 || dbg_state !== 2'd1) begin
         errors++;
         $display("FAIL vout before vin: got empty=%b busy=%b state=%0d expected 1/1/1",
                  bus.EMPTY, bus.BUSY, dbg_state);
      end
      bus.VIN = 1'b1;
      step();
      bus.VIN = 1'b0;
      exp_q.push_back(12'h007);
      drive_sample(12'h007);
      exp_q.push_back(12'h008);
      drive_sample(12'h008);
      checks++;
      if (bus.DONE !== 1'b1) begin
         errors++;
         $display("FAIL vout before vin done: got %b expected 1", bus.DONE);
      end
      drain("vinfirst");
      // NSAMP=0 behaves as one sample
      pulse_start(16'd0);
      bus.VIN  = 1'b1;
      bus.VOUT = 1'b1;
      bus.DOUT = 12'h3C3;
      exp_q.push_back(12'h3C3);
      step();
      bus.VIN  = 1'b0;
      bus.VOUT = 1'b0;
      checks++;
      if (bus.DONE !== 1'b1 || bus.BUSY !== 1'b0) begin
         errors++;
         $display("FAIL nsamp zero: got done=%b busy=%b expected 1/0", bus.DONE, bus.BUSY);
      end
      drive_sample(12'h555);   // after the run: ignored
      drain("nsamp0");
   endtask

   task automatic test_rst_mid();
      pulse_start(16'd10);
      bus.VIN = 1'b1;
      step();
      bus.VIN = 1'b0;
      for (int i = 0; i < 5; i++) drive_sample(NB'(12'h200 + i));
      bus.RD_REQ = 1'b1;       // leave RD_VALID high going into reset
      step();
      bus.RD_REQ = 1'b0;
      checks++;
      if (bus.BUSY !== 1'b1 || bus.EMPTY !== 1'b0 || bus.RD_VALID !== 1'b1) begin
         errors++;
         $display("FAIL rst mid pre: got busy=%b empty=%b valid=%b expected 1/0/1",
                  bus.BUSY, bus.EMPTY, bus.RD_VALID);
      end
      RST = 1'b1;
      step();
      RST = 1'b0;
      checks++;
      if (bus.EMPTY !== 1'b1 || bus.BUSY !== 1'b0 || bus.DONE !== 1'b0 ||
          bus.LAT !== 16'd0 || bus.RD_VALID !== 1'b0) begin
         errors++;
         $display("FAIL rst mid: got empty=%b busy=%b done=%b lat=%0d valid=%b expected 1/0/0/0/0",
                  bus.EMPTY, bus.BUSY, bus.DONE, bus.LAT, bus.RD_VALID);
      end
   endtask

`ifdef IIR_CAPTURE_CHECKSUM_EN
   task automatic test_checksum();
      pulse_start(16'd2);
      checks++;
      if (bus.CHKSUM !== 12'h000) begin
         errors++;
         $display("FAIL chk start: got %h expected 000", bus.CHKSUM);
      end
      bus.VIN = 1'b1;
      step();
      bus.VIN = 1'b0;
      drive_sample(12'h001);
      checks++;
      if (bus.CHKSUM !== 12'h001) begin
         errors++;
         $display("FAIL chk first: got %h expected 001", bus.CHKSUM);
      end
      drive_sample(12'h002);
      checks++;
      if (bus.CHKSUM !== 12'h000) begin
         errors++;
         $display("FAIL chk second: got %h expected 000", bus.CHKSUM);
      end
      pulse_start(16'd1);
      bus.VIN  = 1'b1;
      bus.VOUT = 1'b1;
      bus.DOUT = 12'h803;
      step();
      bus.VIN  = 1'b0;
      bus.VOUT = 1'b0;
      checks++;
      if (bus.CHKSUM !== 12'h803) begin
         errors++;
         $display("FAIL chk third: got %h expected 803", bus.CHKSUM);
      end
      pulse_start(16'd1);
      checks++;
      if (bus.CHKSUM !== 12'h000) begin
         errors++;
         $display("FAIL chk clear: got %h expected 000", bus.CHKSUM);
      end
   endtask
`endif

   initial begin
      RST = 1'b1;
      clear_inputs();
      test_reset();
      test_latency_basic();
      test_overflow();
      test_full_rw();
      test_empty_pop();
      test_rst_mid();
`ifdef IIR_CAPTURE_CHECKSUM_EN
      test_checksum();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
